// File: rtl/crc8_pkg.sv
// ---------------------------------------------------------------------------
// crc8_pkg
// Shared CRC-8 definitions for the frame checker and the parallel generator.
//   CRC_W        : CRC register width (8)
//   POLY_DEFAULT : x^8+x^2+x+1, with the x^8 term implicit
//   state_t      : checker FSM encodings (IDLE=0, RECV=1, DONE=2)
//   crc8_step    : advance the CRC register by one byte, MSB first
// ---------------------------------------------------------------------------
package crc8_pkg;

    localparam int                CRC_W        = 8;
    localparam logic [CRC_W-1:0]  POLY_DEFAULT = 8'h07;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte-wide step: XOR the byte into the register, then eight serial shifts
    // with polynomial feedback. Init 0, no reflection, no final XOR.
    function automatic logic [CRC_W-1:0] crc8_step(
        input logic [CRC_W-1:0] rem,
        input logic [7:0]       data,
        input logic [CRC_W-1:0] poly
    );
        logic [CRC_W-1:0] r;
        r = rem ^ data;
        for (int i = 0; i < 8; i++) begin
            if (r[CRC_W-1]) begin
                r = (r << 1) ^ poly;
            end else begin
                r = r << 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc8_byte_step.sv
// ---------------------------------------------------------------------------
// crc8_byte_step
// Combinational one-byte CRC-8 update.
//   rem_in  : current CRC register
//   data    : byte to absorb, data[7] is the first serial bit
//   rem_out : register after absorbing the byte
// ---------------------------------------------------------------------------
module crc8_byte_step
    import crc8_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = POLY_DEFAULT
) (
    input  logic [CRC_W-1:0] rem_in,
    input  logic [7:0]       data,
    output logic [CRC_W-1:0] rem_out
);

    assign rem_out = crc8_step(rem_in, data, POLY);

endmodule

// File: rtl/crc8_frame_checker.sv
// ---------------------------------------------------------------------------
// crc8_frame_checker
// Receive-side CRC-8 check of fixed-length frames: DATA_BYTES payload bytes
// followed by one CRC byte. Reports pass/fail one cycle after the CRC byte
// and keeps saturating pass/fail statistics.
//
// Handshake: a byte is transferred on a rising edge where in_valid and
// in_ready are both 1. in_ready depends only on FSM state (low only during
// the single DONE cycle), never on in_valid.
//
// Ports:
//   CLK, RST     : clock, asynchronous active-high reset
//   in_data      : frame byte (MSB first), in_valid qualifies, in_sof marks byte 1
//   in_ready     : checker can accept a byte
//   crc_done     : one-cycle result pulse; crc_ok / crc_err valid with it
//   remainder    : CRC register; syndrome after the last byte, held until next SOF
//   frame_abort  : one-cycle pulse, a running frame was discarded by a new SOF
//   ok_cnt       : passed frames, saturating
//   err_cnt      : failed frames, saturating (aborts not counted)
//   dbg_state    : current FSM state encoding
// ---------------------------------------------------------------------------
module crc8_frame_checker
    import crc8_pkg::*;
#(
    parameter int               DATA_BYTES = 8,
    parameter logic [CRC_W-1:0] POLY       = POLY_DEFAULT,
    parameter int               CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic             crc_done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [CRC_W-1:0] remainder,
    output logic             frame_abort,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       dbg_state
);

    // Byte counter must reach DATA_BYTES+1 (the CRC byte).
    localparam int BC_W = $clog2(DATA_BYTES + 2);

    state_t             state, state_n;
    logic [BC_W-1:0]    cnt, cnt_n;
    logic [CRC_W-1:0]   rem, rem_n;
    logic               abort_q, abort_n;
    logic               accept;
    logic [CRC_W-1:0]   step_in, step_out;

    assign accept = in_valid & in_ready;

    // Any SOF restarts from the init value; otherwise continue the running CRC.
    assign step_in = (state == RECV && !in_sof) ? rem : '0;

    crc8_byte_step #(.POLY(POLY)) u_step (
        .rem_in  (step_in),
        .data    (in_data),
        .rem_out (step_out)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rem_n   = rem;
        abort_n = 1'b0;
        case (state)
            IDLE: begin
                // Bytes without SOF while idle are dropped.
                if (accept && in_sof) begin
                    rem_n   = step_out;
                    cnt_n   = BC_W'(1);
                    state_n = RECV;
                end
            end
            RECV: begin
                if (accept) begin
                    rem_n = step_out;
                    if (in_sof) begin
                        cnt_n   = BC_W'(1);
                        abort_n = 1'b1;
                    end else begin
                        cnt_n = cnt + BC_W'(1);
                        // cnt holds bytes already taken, so this byte is the CRC byte.
                        if (cnt == BC_W'(DATA_BYTES)) begin
                            state_n = DONE;
                        end
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rem     <= rem_n;
            abort_q <= abort_n;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ok_cnt  <= '0;
            err_cnt <= '0;
        end else if (state == DONE) begin
            if (rem == '0) begin
                if (ok_cnt != '1) ok_cnt <= ok_cnt + CNT_W'(1);
            end else begin
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready    = (state != DONE);
    assign crc_done    = (state == DONE);
    assign crc_ok      = crc_done && (rem == '0);
    assign crc_err     = crc_done && (rem != '0);
    assign remainder   = rem;
    assign frame_abort = abort_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_crc8_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_crc8_frame_checker
// Two checker instances: A (8 payload bytes, 16-bit counters) and
// B (9 payload bytes, 2-bit counters). Directed frames with hand-computed
// CRCs; expected results go into per-instance queues and a monitor compares
// them whenever crc_done is seen.
// ---------------------------------------------------------------------------
module tb_crc8_frame_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A
    logic [7:0]  a_data;
    logic        a_valid, a_sof;
    logic        a_ready, a_done, a_ok, a_err, a_abort;
    logic [7:0]  a_rem;
    logic [15:0] a_okc, a_errc;
    logic [1:0]  a_st;

    // Instance B
    logic [7:0]  b_data;
    logic        b_valid, b_sof;
    logic        b_ready, b_done, b_ok, b_err, b_abort;
    logic [7:0]  b_rem;
    logic [1:0]  b_okc, b_errc;
    logic [1:0]  b_st;

    crc8_frame_checker #(.DATA_BYTES(8), .POLY(8'h07), .CNT_W(16)) dut_a (
        .CLK(clk), .RST(rst),
        .in_data(a_data), .in_valid(a_valid), .in_sof(a_sof), .in_ready(a_ready),
        .crc_done(a_done), .crc_ok(a_ok), .crc_err(a_err), .remainder(a_rem),
        .frame_abort(a_abort), .ok_cnt(a_okc), .err_cnt(a_errc), .dbg_state(a_st)
    );

    crc8_frame_checker #(.DATA_BYTES(9), .POLY(8'h07), .CNT_W(2)) dut_b (
        .CLK(clk), .RST(rst),
        .in_data(b_data), .in_valid(b_valid), .in_sof(b_sof), .in_ready(b_ready),
        .crc_done(b_done), .crc_ok(b_ok), .crc_err(b_err), .remainder(b_rem),
        .frame_abort(b_abort), .ok_cnt(b_okc), .err_cnt(b_errc), .dbg_state(b_st)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [9:0] exp_a_q[$];   // {crc_ok, crc_err, remainder}
    logic [9:0] exp_b_q[$];
    int exp_abort_a = 0;

    localparam logic [9:0] RES_OK     = {2'b10, 8'h00};
    localparam logic [9:0] RES_ERR_07 = {2'b01, 8'h07};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("a_ready_vs_done", {31'd0, a_ready}, {31'd0, !a_done});
            if (a_done) begin
                if (exp_a_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_done: got done=1 expected no result at %0t", $time);
                end else begin
                    check("a_result", {22'd0, a_ok, a_err, a_rem}, {22'd0, exp_a_q.pop_front()});
                end
            end else begin
                check("a_flags_outside_done", {30'd0, a_ok, a_err}, 32'd0);
            end
            if (a_abort) begin
                checks++;
                if (exp_abort_a == 0) begin
                    errors++;
                    $display("FAIL a_abort: got pulse expected none at %0t", $time);
                end else begin
                    exp_abort_a--;
                end
            end

            check("b_ready_vs_done", {31'd0, b_ready}, {31'd0, !b_done});
            check("b_no_abort", {31'd0, b_abort}, 32'd0);
            if (b_done) begin
                if (exp_b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_done: got done=1 expected no result at %0t", $time);
                end else begin
                    check("b_result", {22'd0, b_ok, b_err, b_rem}, {22'd0, exp_b_q.pop_front()});
                end
            end else begin
                check("b_flags_outside_done", {30'd0, b_ok, b_err}, 32'd0);
            end
        end
    end

    // ---------------- drivers ----------------
    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input int which, input logic [7:0] d, input logic s, input int gap);
        int guard;
        guard = 0;
        repeat (gap) @(negedge clk);
        while (!((which == 1) ? b_ready : a_ready) && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 16) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got in_ready=0 for %0d cycles expected 1", guard);
        end
        if (which == 1) begin
            b_data = d; b_sof = s; b_valid = 1'b1;
        end else begin
            a_data = d; a_sof = s; a_valid = 1'b1;
        end
        @(negedge clk);
        a_valid = 1'b0; a_sof = 1'b0;
        b_valid = 1'b0; b_sof = 1'b0;
    endtask

    task automatic send_frame(input int which, input logic [7:0] pl[$], input logic [7:0] crc,
                              input logic [9:0] exp, input int gapmax);
        for (int i = 0; i < pl.size(); i++) begin
            send_byte(which, pl[i], (i == 0), (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        end
        if (which == 1) exp_b_q.push_back(exp);
        else            exp_a_q.push_back(exp);
        send_byte(which, crc, 1'b0, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        // Result must be presented the cycle right after the CRC byte edge.
        check("done_latency", {31'd0, (which == 1) ? b_done : a_done}, 32'd1);
    endtask

    logic [7:0] zeros8[$] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] z7_01[$]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    logic [7:0] ascii9[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    initial begin
        a_data = '0; a_valid = 1'b0; a_sof = 1'b0;
        b_data = '0; b_valid = 1'b0; b_sof = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_a_ready", {31'd0, a_ready}, 32'd1);
        check("rst_a_done", {31'd0, a_done}, 32'd0);
        check("rst_a_rem", {24'd0, a_rem}, 32'd0);
        check("rst_a_cnts", {a_okc, a_errc}, 32'd0);
        check("rst_a_state", {30'd0, a_st}, 32'd0);
        check("rst_b_cnts", {28'd0, b_okc, b_errc}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // All-zero frame, CRC 00
        send_frame(0, zeros8, 8'h00, RES_OK, 0);
        // 00x7,01 -> CRC 07 good; with 06 the syndrome is step(0,01) = 07
        send_frame(0, z7_01, 8'h07, RES_OK, 0);
        send_frame(0, z7_01, 8'h06, RES_ERR_07, 0);
        @(negedge clk);
        check("a_ok_cnt_3f", {16'd0, a_okc}, 32'd2);
        check("a_err_cnt_3f", {16'd0, a_errc}, 32'd1);
        check("a_rem_hold", {24'd0, a_rem}, 32'h07);

        // Non-SOF bytes while idle are dropped
        send_byte(0, 8'h5A, 1'b0, 0);
        send_byte(0, 8'hA5, 1'b0, 0);
        send_byte(0, 8'hFF, 1'b0, 0);
        check("drop_state_idle", {30'd0, a_st}, 32'd0);
        check("drop_rem_held", {24'd0, a_rem}, 32'h07);
        check("drop_cnts", {a_okc, a_errc}, {16'd2, 16'd1});

        // Abort after 4 bytes, then a full good frame
        send_byte(0, 8'hAA, 1'b1, 0);
        send_byte(0, 8'hBB, 1'b0, 0);
        send_byte(0, 8'hCC, 1'b0, 0);
        send_byte(0, 8'hDD, 1'b0, 0);
        check("abort_state_recv", {30'd0, a_st}, 32'd1);
        exp_abort_a++;
        send_frame(0, z7_01, 8'h07, RES_OK, 0);
        @(negedge clk);
        check("abort_ok_cnt", {16'd0, a_okc}, 32'd3);
        check("abort_err_cnt", {16'd0, a_errc}, 32'd1);
        check("abort_pulse_seen", exp_abort_a, 32'd0);

        // Good frame with random valid gaps
        send_frame(0, z7_01, 8'h07, RES_OK, 3);
        send_frame(0, zeros8, 8'h00, RES_OK, 2);
        @(negedge clk);
        check("gaps_ok_cnt", {16'd0, a_okc}, 32'd5);

        // Instance B: "123456789" check value F4
        send_frame(1, ascii9, 8'hF4, RES_OK, 0);
        send_frame(1, ascii9, 8'hF5, RES_ERR_07, 0);
        @(negedge clk);
        check("b_ok_cnt_1", {30'd0, b_okc}, 32'd1);
        check("b_err_cnt_1", {30'd0, b_errc}, 32'd1);
        for (int n = 0; n < 5; n++) begin
            send_frame(1, ascii9, 8'hF4, RES_OK, 1);
        end
        @(negedge clk);
        check("b_ok_cnt_sat", {30'd0, b_okc}, 32'd3);
        check("b_err_cnt_kept", {30'd0, b_errc}, 32'd1);

        // Reset in the middle of a frame
        send_byte(0, 8'h12, 1'b1, 0);
        send_byte(0, 8'h34, 1'b0, 0);
        send_byte(0, 8'h56, 1'b0, 0);
        check("pre_rst_state", {30'd0, a_st}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_a_state", {30'd0, a_st}, 32'd0);
        check("midrst_a_rem", {24'd0, a_rem}, 32'd0);
        check("midrst_a_cnts", {a_okc, a_errc}, 32'd0);
        check("midrst_b_cnts", {28'd0, b_okc, b_errc}, 32'd0);
        check("midrst_a_ready", {31'd0, a_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_no_pulse", {30'd0, a_done, a_abort}, 32'd0);

        // Fresh frame after reset still checks correctly
        send_frame(0, z7_01, 8'h07, RES_OK, 0);
        repeat (2) @(negedge clk);
        check("post_rst_ok_cnt", {16'd0, a_okc}, 32'd1);
        check("a_queue_drained", exp_a_q.size(), 32'd0);
        check("b_queue_drained", exp_b_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected test end");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
